// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM encoding and frame constants.
package uart_loader_pkg;

   // Loader FSM states (2-bit encoding)
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LEN  = 2'd1,
      ST_DATA = 2'd2,
      ST_CHK  = 2'd3
   } state_e;

   // Frame start marker
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_word_packer.sv
// Byte-to-word assembler: shifts bytes in MSB-first and flags the last byte of each word.
// word_c_o / word_valid_c_o are combinational views of the word being completed this cycle.
module uart_word_packer #(
   parameter int unsigned WORD_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_i,
   output logic [WORD_W-1:0] word_c_o,
   output logic              word_valid_c_o
);

   localparam int unsigned BYTES    = WORD_W / 8;
   localparam int unsigned CNT_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

   logic [WORD_W-1:0] word_q, word_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Shifted word including the incoming byte; upper bytes fall off the top
   assign word_c_o       = WORD_W'({word_q, byte_i});
   assign word_valid_c_o = byte_valid_i && !clear_i && (cnt_q == CNT_LAST);

   // Next-state for shift register and byte counter
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (byte_valid_i) begin
         word_d = word_c_o;
         cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Assembler state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_loader.sv
// UART frame loader: SYNC, COUNT, payload words (MSB-first), optional XOR checksum.
// Writes words to memory from address 0 and holds the CPU in reset while loading.
// Optional feature: define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned WORD_W  = 16,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_done_tick,
   input  logic [7:0]        rx_byte,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [7:0]        n_q, n_d;
   logic [7:0]        wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   logic              in_data_c;
   logic [WORD_W-1:0] word_c;
   logic              word_valid_c;
   logic              expire_c;

   assign in_data_c = (state_q == ST_DATA);
   // Inter-byte timeout fires only on a silent cycle; a coinciding byte wins
   assign expire_c  = (state_q != ST_IDLE) && !rx_done_tick && (tmo_q == TMO_LAST);

   uart_word_packer #(
      .WORD_W (WORD_W)
   ) u_packer (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear_i        (!in_data_c),
      .byte_valid_i   (rx_done_tick && in_data_c),
      .byte_i         (rx_byte),
      .word_c_o       (word_c),
      .word_valid_c_o (word_valid_c)
   );

   // Next-state and output logic for the frame FSM
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      wcnt_d      = wcnt_q;
      idx_d       = idx_q;
      tmo_d       = '0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      chk_d       = chk_q;
`endif

      if (state_q != ST_IDLE && !rx_done_tick) begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (rx_done_tick && rx_byte == SYNC_BYTE) begin
               state_d    = ST_LEN;
               cpu_hold_d = 1'b1;
            end
         end
         ST_LEN: begin
            if (rx_done_tick) begin
               if (rx_byte == 8'h00) begin
                  state_d    = ST_IDLE;
                  load_err_d = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  state_d    = ST_DATA;
                  n_d        = rx_byte;
                  wcnt_d     = '0;
                  idx_d      = '0;
                  mem_addr_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                  chk_d      = '0;
`endif
               end
            end
         end
         ST_DATA: begin
            if (rx_done_tick) begin
`ifdef UART_LOADER_CHECKSUM_EN
               chk_d = chk_q ^ rx_byte;
`endif
               if (word_valid_c) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = idx_q;
                  mem_wdata_d = word_c;
                  idx_d       = idx_q + ADDR_W'(1);
                  wcnt_d      = wcnt_q + 8'd1;
                  if (wcnt_q == 8'(n_q - 8'd1)) begin
`ifdef UART_LOADER_CHECKSUM_EN
                     state_d     = ST_CHK;
`else
                     state_d     = ST_IDLE;
                     load_done_d = 1'b1;
                     cpu_hold_d  = 1'b0;
`endif
                  end
               end
            end
         end
`ifdef UART_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (rx_done_tick) begin
               state_d    = ST_IDLE;
               cpu_hold_d = 1'b0;
               if (rx_byte == chk_q) begin
                  load_done_d = 1'b1;
               end else begin
                  load_err_d  = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d    = ST_IDLE;
            cpu_hold_d = 1'b0;
         end
      endcase

      // Abort on inter-byte silence; no byte is consumed this cycle
      if (expire_c) begin
         state_d    = ST_IDLE;
         load_err_d = 1'b1;
         cpu_hold_d = 1'b0;
         mem_we_d   = 1'b0;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         n_q         <= '0;
         wcnt_q      <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         wcnt_q      <= wcnt_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
`ifdef UART_LOADER_CHECKSUM_EN
         chk_q       <= chk_d;
`endif
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader (WORD_W=16, ADDR_W=8, short TIMEOUT).
module tb_uart_loader;

   localparam int unsigned WORD_W  = 16;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned TIMEOUT = 20;

   logic              clk;
   logic              reset_n;
   logic              rx_done_tick;
   logic [7:0]        rx_byte;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;

   int n_cmp;
   int n_bad;
   int done_cnt;
   int err_cnt;
   int both_cnt;
   logic [ADDR_W-1:0] wa_q[$];
   logic [WORD_W-1:0] wd_q[$];

   uart_loader #(
      .WORD_W  (WORD_W),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_done_tick (rx_done_tick),
      .rx_byte      (rx_byte),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_err     (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record writes and pulses at the inactive edge
   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
         end
         if (load_done) done_cnt++;
         if (load_err) err_cnt++;
         if (load_done && load_err) both_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Present one byte for exactly one rising edge; returns at the following negedge
   task automatic send_byte(input logic [7:0] b);
      rx_byte      = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic test_reset();
      n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
      n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
      n_cmp++; if (mem_wdata !== 16'h0000) begin n_bad++; $display("FAIL reset_wdata: got %h want 0000", mem_wdata); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b want 0", cpu_hold); end
      n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", load_done); end
      n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", load_err); end
   endtask

   task automatic test_basic_frame();
      int d0;
      d0 = done_cnt;
      clear_log();
      send_byte(8'hA5);
      n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL basic_hold_on: got %b want 1", cpu_hold); end
      idle(1);
      send_byte(8'h02); idle(2);
      send_byte(8'h12); idle(2);
      send_byte(8'h34);
      n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL basic_we0: got %b want 1", mem_we); end
      n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL basic_addr0: got %h want 00", mem_addr); end
      n_cmp++; if (mem_wdata !== 16'h1234) begin n_bad++; $display("FAIL basic_data0: got %h want 1234", mem_wdata); end
      idle(2);
      send_byte(8'h56); idle(2);
      send_byte(8'h78);
      n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL basic_we1: got %b want 1", mem_we); end
      n_cmp++; if (mem_addr !== 8'h01) begin n_bad++; $display("FAIL basic_addr1: got %h want 01", mem_addr); end
      n_cmp++; if (mem_wdata !== 16'h5678) begin n_bad++; $display("FAIL basic_data1: got %h want 5678", mem_wdata); end
`ifdef UART_LOADER_CHECKSUM_EN
      idle(2);
      send_byte(8'h08);
`endif
      n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", load_done); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL basic_hold_off: got %b want 0", cpu_hold); end
      idle(1);
      n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", load_done); end
      n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 2", wa_q.size()); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL basic_ndone: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_ignore_noise();
      clear_log();
      send_byte(8'h00); idle(1);
      send_byte(8'hFF); idle(1);
      n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL noise_hold: got %b want 0", cpu_hold); end
      send_byte(8'hA5); idle(1);
      send_byte(8'h01); idle(1);
      send_byte(8'hAB); idle(1);
      send_byte(8'hCD);
`ifdef UART_LOADER_CHECKSUM_EN
      idle(1);
      send_byte(8'h66);
`endif
      n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL noise_done: got %b want 1", load_done); end
      idle(1);
      n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL noise_nwrites: got %0d want 1", wa_q.size()); end
      else begin
         n_cmp++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 16'hABCD) begin
            n_bad++; $display("FAIL noise_write: got %h=%h want 00=abcd", wa_q[0], wd_q[0]);
         end
      end
   endtask

   task automatic test_zero_count();
      clear_log();
      send_byte(8'hA5); idle(1);
      send_byte(8'h00);
      n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL zero_err: got %b want 1", load_err); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL zero_hold: got %b want 0", cpu_hold); end
      n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL zero_done: got %b want 0", load_done); end
      idle(2);
      n_cmp++; if (wa_q.size() !== 0) begin n_bad++; $display("FAIL zero_nwrites: got %0d want 0", wa_q.size()); end
   endtask

   task automatic test_timeout();
      logic early;
      int   d0;
      d0 = done_cnt;
      clear_log();
      send_byte(8'hA5); idle(1);
      send_byte(8'h02); idle(1);
      send_byte(8'h12);
      early = 1'b0;
      for (int k = 1; k < int'(TIMEOUT); k++) begin
         @(negedge clk);
         if (load_err) early = 1'b1;
      end
      n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b want 0", early); end
      @(negedge clk);
      n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b want 1", load_err); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL tmo_hold: got %b want 0", cpu_hold); end
      // Remainder of the abandoned frame must be ignored
      idle(1);
      send_byte(8'h34); idle(1);
      send_byte(8'h56); idle(1);
      send_byte(8'h78); idle(1);
      send_byte(8'h08); idle(2);
      n_cmp++; if (wa_q.size() !== 0) begin n_bad++; $display("FAIL tmo_nwrites: got %0d want 0", wa_q.size()); end
      n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL tmo_ndone: got %0d want %0d", done_cnt, d0); end
   endtask

   task automatic test_timeout_edge();
      int e0;
      e0 = err_cnt;
      clear_log();
      send_byte(8'hA5); idle(1);
      send_byte(8'h02); idle(1);
      send_byte(8'h12);
      idle(int'(TIMEOUT) - 1);
      send_byte(8'h34);
      n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL edge_err: got %b want 0", load_err); end
      n_cmp++; if (mem_we !== 1'b1 || mem_wdata !== 16'h1234) begin
         n_bad++; $display("FAIL edge_write: got we=%b data=%h want we=1 data=1234", mem_we, mem_wdata);
      end
      idle(int'(TIMEOUT) - 1);
      send_byte(8'h56); idle(1);
      send_byte(8'h78);
`ifdef UART_LOADER_CHECKSUM_EN
      idle(1);
      send_byte(8'h08);
`endif
      n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL edge_done: got %b want 1", load_done); end
      idle(1);
      n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL edge_nerr: got %0d want %0d", err_cnt, e0); end
      n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL edge_nwrites: got %0d want 2", wa_q.size()); end
   endtask

`ifdef UART_LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      int d0;
      d0 = done_cnt;
      clear_log();
      send_byte(8'hA5); idle(1);
      send_byte(8'h01); idle(1);
      send_byte(8'hAB); idle(1);
      send_byte(8'hCD); idle(1);
      send_byte(8'h67);
      n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL chk_err: got %b want 1", load_err); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL chk_hold: got %b want 0", cpu_hold); end
      idle(2);
      n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL chk_ndone: got %0d want %0d", done_cnt, d0); end
      n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL chk_nwrites: got %0d want 1", wa_q.size()); end
   endtask
`endif

   task automatic test_reset_mid_frame();
      send_byte(8'hA5); idle(1);
      send_byte(8'h02); idle(1);
      send_byte(8'h12); idle(1);
      send_byte(8'h34); idle(1);
      clear_log();
      send_byte(8'h56);
      reset_n = 1'b0;
      #1;
      n_cmp++; if ({mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !== '0) begin
         n_bad++; $display("FAIL midrst_outputs: got we=%b addr=%h data=%h hold=%b done=%b err=%b want all 0",
                           mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err);
      end
      idle(3);
      reset_n = 1'b1;
      idle(2);
      n_cmp++; if (wa_q.size() !== 0) begin n_bad++; $display("FAIL midrst_nwrites: got %0d want 0", wa_q.size()); end
      send_byte(8'hA5); idle(1);
      send_byte(8'h02); idle(1);
      send_byte(8'h12); idle(1);
      send_byte(8'h34); idle(1);
      send_byte(8'h56); idle(1);
      send_byte(8'h78);
`ifdef UART_LOADER_CHECKSUM_EN
      idle(1);
      send_byte(8'h08);
`endif
      n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL midrst_done: got %b want 1", load_done); end
      idle(1);
      n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL midrst_nwrites2: got %0d want 2", wa_q.size()); end
      else begin
         n_cmp++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 16'h1234) begin
            n_bad++; $display("FAIL midrst_w0: got %h=%h want 00=1234", wa_q[0], wd_q[0]);
         end
         n_cmp++; if (wa_q[1] !== 8'h01 || wd_q[1] !== 16'h5678) begin
            n_bad++; $display("FAIL midrst_w1: got %h=%h want 01=5678", wa_q[1], wd_q[1]);
         end
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      done_cnt     = 0;
      err_cnt      = 0;
      both_cnt     = 0;
      reset_n      = 1'b0;
      rx_done_tick = 1'b0;
      rx_byte      = 8'h00;
      idle(3);
      test_reset();
      reset_n = 1'b1;
      idle(2);
      test_basic_frame();
      idle(3);
      test_ignore_noise();
      idle(3);
      test_zero_count();
      idle(3);
      test_timeout();
      idle(3);
      test_timeout_edge();
      idle(3);
`ifdef UART_LOADER_CHECKSUM_EN
      test_bad_checksum();
      idle(3);
`endif
      test_reset_mid_frame();
      idle(3);
      n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL done_and_err: got %0d overlaps want 0", both_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning memory word width in bits; legal values 8, 16, 24, 32.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 50000, meaning the inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on the rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port rx_done_tick  input  1  one-cycle strobe marking that rx_byte is valid.
REQ-007 SHALL have port rx_byte  input  8  byte received from the UART receiver.
REQ-008 SHALL have port mem_we  output  1  one-cycle memory write strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-010 SHALL have port mem_wdata  output  WORD_W  write data.
REQ-011 SHALL have port cpu_hold  output  1  holds the processor in reset while a load is in progress.
REQ-012 SHALL have port load_done  output  1  one-cycle pulse on successful frame completion.
REQ-013 SHALL have port load_err  output  1  one-cycle pulse on frame abort.

Function
REQ-014 SHALL accept the frame format: SYNC byte 0xA5, then COUNT byte N, then N*(WORD_W/8) payload bytes MSB-first per word, then (if CHECKSUM_EN) one XOR checksum byte.
REQ-015 SHALL implement FSM states IDLE, LEN, DATA, CHK, with transitions taken only on rx_done_tick except for abort.
REQ-016 SHALL in IDLE ignore every byte except 0xA5; on 0xA5 it goes to LEN and sets cpu_hold=1.
REQ-017 SHALL in LEN, on N=0, pulse load_err, clear cpu_hold and go to IDLE; otherwise it latches N, clears address and checksum, and goes to DATA.
REQ-018 SHALL in DATA shift each byte into the word assembler; on the last byte of a word, assert mem_we for exactly one cycle on the next cycle, with mem_addr = word index (from 0) and mem_wdata = assembled word.
REQ-019 SHALL hold mem_addr and mem_wdata stable while mem_we=1; the address increments after each write and wraps modulo 2^ADDR_W.
REQ-020 SHALL, after word N is written, go to CHK (CHECKSUM_EN) or finish.
REQ-021 SHALL on finish pulse load_done one cycle after the final byte's rx_done_tick, clear cpu_hold in that same cycle, and return to IDLE.
REQ-022 SHALL count clk cycles since the last rx_done_tick in states LEN, DATA and CHK; on reaching TIMEOUT it pulses load_err, clears cpu_hold, goes to IDLE, and performs no further writes.
REQ-023 SHALL give rx_done_tick priority when it coincides with timeout expiry: the byte is accepted and the counter restarts.
REQ-024 SHALL never assert load_done and load_err in the same cycle.

Reset
REQ-025 SHALL, while reset_n=0, force the state to IDLE and all outputs, the counters, the assembler and the checksum to 0.
REQ-026 SHALL on reset mid-frame discard the partial word and not generate mem_we.

Configuration
REQ-027 SHALL, when UART_LOADER_CHECKSUM_EN is defined, XOR all payload bytes and compare the result with the byte received in CHK: a match gives load_done, a mismatch gives load_err (already-written words remain written).
REQ-028 SHALL, when UART_LOADER_CHECKSUM_EN is undefined, omit the CHK state and checksum logic and finish directly after word N.

Structure
REQ-029 SHALL place the FSM state encoding (2-bit) and the SYNC_BYTE constant 8'hA5 in shared package uart_loader_pkg.
REQ-030 SHALL implement byte-to-word packing in sub-module uart_word_packer (shift-in, byte counter, word_valid strobe).

Verification
REQ-031 SHALL cover: WORD_W=16, frame A5 02 12 34 56 78 (+ checksum 08) -> writes addr0=0x1234, addr1=0x5678, then load_done.
REQ-032 SHALL cover: bytes 00 FF then A5 01 AB CD (+ checksum 66) -> 00 and FF ignored, one write addr0=0xABCD.
REQ-033 SHALL cover: A5 00 -> load_err one cycle after the COUNT byte, no mem_we, cpu_hold=0.
REQ-034 SHALL cover: A5 02 12 then silence for TIMEOUT cycles -> load_err, no writes, IDLE; a byte arriving on the expiry cycle is accepted instead.
REQ-035 SHALL cover: CHECKSUM_EN with a wrong checksum byte -> load_err, load_done never asserted.
REQ-036 SHALL cover: reset_n low after the third payload byte -> all outputs 0 immediately, no mem_we; a following full frame loads correctly from addr0.
